// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall, redirect flush and halt
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd100,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        Flush,
  output logic        AlignErr
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        fetch_valid_q;
  logic        flush_q;
  logic        align_err_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_next_seq;

  // Older-stage branch wins over the younger-stage jump when both redirect.
  always_comb begin
    redirect        = BranchTaken | Jump;
    redirect_target = JumpTarget;
    if (BranchTaken) begin
      redirect_target = BranchTarget;
    end
  end

  // Sequential successor; wraps naturally at 32 bits.
  assign pc_next_seq = pc_q + STEP;

  // FSM, PC register and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b1;
      flush_q       <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      flush_q     <= 1'b0;
      align_err_q <= 1'b0;
      case (state)
        RUN, STALL, FLUSH: begin
          if (redirect) begin
            // Low bits are dropped; a misaligned target is flagged, not trapped.
            pc_q          <= {redirect_target[31:2], 2'b00};
            align_err_q   <= (redirect_target[1:0] != 2'b00);
            flush_q       <= 1'b1;
            state         <= FLUSH;
            fetch_valid_q <= 1'b0;
          end else if (state == FLUSH) begin
            // Bubble cycle done; the redirected PC is held for issue next.
            if (Stall) begin
              state         <= STALL;
              fetch_valid_q <= 1'b0;
            end else begin
              state         <= RUN;
              fetch_valid_q <= 1'b1;
            end
          end else if (Halt) begin
            state         <= HALTED;
            fetch_valid_q <= 1'b0;
          end else if (Stall) begin
            state         <= STALL;
            fetch_valid_q <= 1'b0;
          end else begin
            pc_q          <= pc_next_seq;
            state         <= RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          // HALTED: frozen until reset.
          state         <= HALTED;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = pc_next_seq;
  assign FetchValid = fetch_valid_q;
  assign Flush      = flush_q;
  assign AlignErr   = align_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        Flush;
  logic        AlignErr;

  int n_checks;
  int n_fails;

  pc_sequencer #(.RESET_PC(32'd100), .STEP(32'd4)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Stall(Stall),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .Halt(Halt),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .FetchValid(FetchValid),
    .Flush(Flush),
    .AlignErr(AlignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic fv,
                            input logic fl, input logic ae);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".pcplus4"}, PCPlus4, pc + 32'd4);
    chk({tag, ".fetchvalid"}, {31'd0, FetchValid}, {31'd0, fv});
    chk({tag, ".flush"}, {31'd0, Flush}, {31'd0, fl});
    chk({tag, ".alignerr"}, {31'd0, AlignErr}, {31'd0, ae});
  endtask

  task automatic idle_inputs();
    Rst          = 1'b0;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'd0;
    Jump         = 1'b0;
    JumpTarget   = 32'd0;
    Halt         = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();

    // Reset with noisy inputs present
    Rst = 1'b1; Jump = 1'b1; JumpTarget = 32'h0000_0800; Halt = 1'b1;
    tick();
    expect_all("reset", 32'd100, 1'b1, 1'b0, 1'b0);
    idle_inputs();

    // Sequential fetch
    tick(); expect_all("seq1", 32'd104, 1'b1, 1'b0, 1'b0);
    tick(); expect_all("seq2", 32'd108, 1'b1, 1'b0, 1'b0);

    // Two-cycle stall at 108
    Stall = 1'b1;
    tick(); expect_all("stall1", 32'd108, 1'b0, 1'b0, 1'b0);
    tick(); expect_all("stall2", 32'd108, 1'b0, 1'b0, 1'b0);
    Stall = 1'b0;
    tick(); expect_all("unstall", 32'd112, 1'b1, 1'b0, 1'b0);

    // Branch beats jump and stall
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0200;
    Jump = 1'b1; JumpTarget = 32'h0000_0400; Stall = 1'b1;
    tick(); expect_all("redir", 32'h0000_0200, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); expect_all("redir_run", 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    tick(); expect_all("redir_seq", 32'h0000_0204, 1'b1, 1'b0, 1'b0);

    // Misaligned jump target
    Jump = 1'b1; JumpTarget = 32'h0000_0302;
    tick(); expect_all("align", 32'h0000_0300, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    tick(); expect_all("align_clr", 32'h0000_0300, 1'b1, 1'b0, 1'b0);

    // Redirect arriving during FLUSH is accepted
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0120;
    tick(); expect_all("fl_a", 32'h0000_0120, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    Jump = 1'b1; JumpTarget = 32'h0000_0600;
    tick(); expect_all("fl_b", 32'h0000_0600, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); expect_all("fl_run", 32'h0000_0600, 1'b1, 1'b0, 1'b0);

    // Halt at 0x120, jumps ignored
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0120;
    tick(); expect_all("h_br", 32'h0000_0120, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); expect_all("h_run", 32'h0000_0120, 1'b1, 1'b0, 1'b0);
    Halt = 1'b1;
    tick(); expect_all("halt", 32'h0000_0120, 1'b0, 1'b0, 1'b0);
    Halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Jump = i[0]; JumpTarget = 32'h0000_0502; Stall = i[1];
      tick(); expect_all($sformatf("halted%0d", i), 32'h0000_0120, 1'b0, 1'b0, 1'b0);
    end
    idle_inputs();
    Rst = 1'b1;
    tick(); expect_all("h_rst", 32'd100, 1'b1, 1'b0, 1'b0);
    Rst = 1'b0;
    tick(); expect_all("h_rst_run", 32'd104, 1'b1, 1'b0, 1'b0);

    // Reset mid-STALL
    Stall = 1'b1;
    tick(); expect_all("s_stall", 32'd104, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    tick(); expect_all("s_rst", 32'd100, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_all("s_rst_run", 32'd104, 1'b1, 1'b0, 1'b0);

    // Reset mid-FLUSH with a misaligned redirect pending
    Jump = 1'b1; JumpTarget = 32'h0000_0701;
    tick(); expect_all("f_flush", 32'h0000_0700, 1'b0, 1'b1, 1'b1);
    Rst = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0903;
    tick(); expect_all("f_rst", 32'd100, 1'b1, 1'b0, 1'b0);
    idle_inputs();

    // PC wrap at 2^32
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick(); expect_all("wrap_br", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); expect_all("wrap_run", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    tick(); expect_all("wrap0", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    tick(); expect_all("wrap4", 32'h0000_0004, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 100, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter STEP, default 4, meaning the sequential PC increment in bytes.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port Stall  input  1  hazard unit requests PC hold.
REQ-006 SHALL have port BranchTaken  input  1  resolved taken branch from the older pipeline stage.
REQ-007 SHALL have port BranchTarget  input  32  branch destination address.
REQ-008 SHALL have port Jump  input  1  jump decoded in the younger pipeline stage.
REQ-009 SHALL have port JumpTarget  input  32  jump destination address.
REQ-010 SHALL have port Halt  input  1  stop fetching until reset.
REQ-011 SHALL have port PC  output  32  current fetch address (registered).
REQ-012 SHALL have port PCPlus4  output  32  PC + STEP, combinational from PC, modulo 2^32.
REQ-013 SHALL have port FetchValid  output  1  high when the instruction at PC is to be issued this cycle.
REQ-014 SHALL have port Flush  output  1  one-cycle pulse (registered) squashing the IF/ID register after a redirect.
REQ-015 SHALL have port AlignErr  output  1  one-cycle pulse (registered) when a taken target has nonzero bits [1:0].

Function
REQ-016 SHALL implement states RUN, STALL, FLUSH, HALTED; encoding free.
REQ-017 Next-PC priority per cycle, highest first, SHALL be: BranchTaken -> BranchTarget; Jump -> JumpTarget; Halt -> hold; Stall -> hold; else PC + STEP.
REQ-018 Redirect (BranchTaken or Jump) SHALL be honoured in RUN and STALL, overriding Stall and Halt in the same cycle.
REQ-019 Redirect SHALL load PC with target bits [31:2] and bits [1:0] forced to 00, and SHALL assert AlignErr next cycle if target bits [1:0] != 00.
REQ-020 Redirect SHALL move to FLUSH and assert Flush for exactly the following cycle.
REQ-021 FLUSH SHALL last one cycle: FetchValid=0, PC held, then to STALL if Stall high else RUN; a redirect arriving in FLUSH SHALL be accepted (PC reloaded, FLUSH repeated).
REQ-022 RUN with Stall=1 and no redirect SHALL hold PC and enter STALL; STALL with Stall=0 SHALL return to RUN and advance PC by STEP that cycle.
REQ-023 FetchValid SHALL equal 1 in RUN and 0 in STALL, FLUSH, HALTED.
REQ-024 Halt=1 with no redirect in RUN or STALL SHALL enter HALTED; HALTED SHALL hold PC and ignore all inputs except Rst.
REQ-025 PC + STEP SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000) with no flag.
REQ-026 Stall, Halt, Jump, BranchTaken SHALL be sampled only on Clk rising edges; no combinational path from them to PC.

Reset
REQ-027 Rst=1 at a rising edge SHALL set PC=RESET_PC, state=RUN, Flush=0, AlignErr=0, regardless of any other input.
REQ-028 Rst SHALL take effect mid-FLUSH, mid-STALL and in HALTED identically; first cycle after Rst deasserts SHALL have FetchValid=1 and PC=RESET_PC.
REQ-029 Between reset and the first clock edge PC value SHALL be undefined; no initial-block value is relied upon.

Verification
REQ-030 Rst 1 cycle, then 3 idle cycles -> PC 100, 104, 108, 112; FetchValid=1 throughout; PCPlus4 always PC+4.
REQ-031 At PC=108 Stall=1 for 2 cycles -> PC holds 108 two cycles, FetchValid=0, then 112.
REQ-032 BranchTaken=1 (target 0x200) and Jump=1 (target 0x400) and Stall=1 same cycle -> PC=0x200, Flush=1 next cycle, FetchValid=0 that cycle, then 0x204.
REQ-033 Jump target 0x00000302 -> PC=0x300, AlignErr pulses exactly one cycle.
REQ-034 Halt=1 at PC=0x120 -> PC frozen at 0x120 for 10 cycles despite Jump pulses; Rst -> PC=100, RUN.
REQ-035 Force PC to 0xFFFFFFFC via BranchTarget, then idle -> PC 0xFFFFFFFC, then 0x00000000, 0x00000004.
